// File: rtl/messbauer_pkg.sv
// Shared constants, sequencer state and per-sweep configuration for the
// Mossbauer sweep sequencer.
package messbauer_pkg;
  localparam int CHANNEL_W    = 12;
  localparam int MAX_CHANNELS = 4096;
  localparam int PULSE_W_DEF  = 2;

  typedef enum logic {IDLE, SWEEP} seq_state_e;

  typedef struct packed {
    logic [15:0]          dwell;
    logic [CHANNEL_W-1:0] last;
  } sweep_cfg_t;

  function automatic logic [15:0] eff_dwell(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  // 0 and anything above MAX_CHANNELS both mean a full 4096-channel sweep
  function automatic logic [CHANNEL_W-1:0] last_channel(input logic [12:0] n);
    logic [12:0] eff;
    eff = (n == 13'd0 || n > 13'(MAX_CHANNELS)) ? 13'(MAX_CHANNELS) : n;
    return CHANNEL_W'(eff - 13'd1);
  endfunction
endpackage

// File: rtl/messbauer_pulse_shaper.sv
// Detector conditioning: 2-FF sync, rising-edge detect, pending queue and a
// spaced strobe emitter (PULSE_W high then PULSE_W low per event).
module messbauer_pulse_shaper
  import messbauer_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int PEND_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic det_in,
  input  logic accept,
  input  logic flush,
  output logic count,
  output logic lost
);
  localparam int PH_W = $clog2(2 * PULSE_W);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * PULSE_W - 1);
  localparam logic [PH_W-1:0]   PH_HI    = PH_W'(PULSE_W);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [2:0]        det_pipe;
  logic              rise, inc, drop, done, keep, start_em;
  logic              em_act, em_act_n;
  logic [PH_W-1:0]   ph, ph_n;
  logic [PEND_W-1:0] pend, pend_a, pend_n;

  assign rise = det_pipe[1] & ~det_pipe[2];

  // pend counts the strobe being emitted too; it drops when its low gap ends
  always_comb begin
    done   = em_act && (ph == PH_LAST);
    keep   = em_act && !done;
    inc    = rise && accept && (pend != PEND_MAX);
    drop   = rise && accept && (pend == PEND_MAX);
    pend_a = pend + PEND_W'(inc) - PEND_W'(done);
    pend_n = pend_a;
    lost   = drop;
    if (flush) begin
      pend_n = PEND_W'(keep);
      if (pend_a != PEND_W'(keep)) lost = 1'b1;
    end
    start_em = (!em_act || done) && (pend_n != '0);
    em_act_n = em_act;
    ph_n     = ph;
    if (start_em) begin
      em_act_n = 1'b1;
      ph_n     = '0;
    end else if (done) begin
      em_act_n = 1'b0;
    end else if (em_act) begin
      ph_n = ph + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_pipe <= '0;
      pend     <= '0;
      em_act   <= 1'b0;
      ph       <= '0;
      count    <= 1'b0;
    end else begin
      det_pipe <= {det_pipe[1:0], det_in};
      pend     <= pend_n;
      em_act   <= em_act_n;
      ph       <= ph_n;
      count    <= em_act_n && (ph_n < PH_HI);
    end
  end
endmodule

// File: rtl/messbauer_sweep_sequencer.sv
// Sweep timing front end: splits each sweep into dwell-clock channels and
// emits start/chanel strobes plus conditioned detector counts.
module messbauer_sweep_sequencer
  import messbauer_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int PEND_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 det_in,
  input  logic [15:0]          dwell,
  input  logic [12:0]          n_channels,
  output logic                 start,
  output logic                 chanel,
  output logic                 count,
  output logic [CHANNEL_W-1:0] channel_idx,
  output logic [15:0]          sweep_cnt,
  output logic                 busy,
  output logic                 count_lost
);
  seq_state_e  state, state_n;
  sweep_cfg_t  cfg, cfg_in;
  logic [15:0] dwell_cnt;
  logic [2:0]  str_left;
  logic        ch_end, last, load, adv, lost;

  function automatic logic [2:0] str_m1(input logic [15:0] d);
    return (d >= 16'(PULSE_W)) ? 3'(PULSE_W - 1) : 3'(d - 16'd1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    cfg_in.dwell = eff_dwell(dwell);
    cfg_in.last  = last_channel(n_channels);
    ch_end       = (state == SWEEP) && (dwell_cnt == 16'd1);
    last         = ch_end && (channel_idx == cfg.last);
    adv          = ch_end && !last;
    load         = 1'b0;
    state_n      = state;
    case (state)
      IDLE: if (run) begin
        load    = 1'b1;
        state_n = SWEEP;
      end
      SWEEP: if (last) begin
        if (run) load = 1'b1;
        else     state_n = IDLE;
      end
    endcase
  end

  // dwell_cnt holds the clocks left in the channel, including the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg         <= '0;
      dwell_cnt   <= '0;
      channel_idx <= '0;
      sweep_cnt   <= '0;
      str_left    <= '0;
      start       <= 1'b0;
      chanel      <= 1'b0;
      count_lost  <= 1'b0;
    end else begin
      if (last) sweep_cnt <= sweep_cnt + 16'd1;
      if (state == IDLE && run) count_lost <= 1'b0;
      else if (lost)            count_lost <= 1'b1;
      if (load) begin
        cfg         <= cfg_in;
        dwell_cnt   <= cfg_in.dwell;
        channel_idx <= '0;
        start       <= 1'b1;
        chanel      <= 1'b0;
        str_left    <= str_m1(cfg_in.dwell);
      end else if (adv) begin
        dwell_cnt   <= cfg.dwell;
        channel_idx <= channel_idx + 1'b1;
        start       <= 1'b0;
        chanel      <= 1'b1;
        str_left    <= str_m1(cfg.dwell);
      end else begin
        if (last) channel_idx <= '0;
        if (state == SWEEP) dwell_cnt <= dwell_cnt - 16'd1;
        if (str_left != 3'd0) begin
          str_left <= str_left - 3'd1;
        end else begin
          start  <= 1'b0;
          chanel <= 1'b0;
        end
      end
    end
  end

  assign busy = (state == SWEEP);

  messbauer_pulse_shaper #(.PULSE_W(PULSE_W), .PEND_W(PEND_W)) u_shaper (
    .clk    (clk),
    .rst    (rst),
    .det_in (det_in),
    .accept (busy),
    .flush  (ch_end),
    .count  (count),
    .lost   (lost)
  );
endmodule
